// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush control for the 5-stage pipeline, covering load-use, taken-branch and data-memory wait hazards
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [4:0]             ifid_rs1,
  input  logic [4:0]             ifid_rs2,
  input  logic [4:0]             idex_rd,
  input  logic                   idex_mem_read,
  input  logic                   ex_branch_taken,
  input  logic                   exmem_mem_req,
  input  logic                   dmem_ready,
  output logic                   pc_write,
  output logic                   ifid_write,
  output logic                   ifid_flush,
  output logic                   idex_write,
  output logic                   idex_flush,
  output logic                   exmem_write,
  output logic                   memwb_bubble,
  output logic                   mem_error,
  output logic [STALL_CNT_W-1:0] stall_count
);
  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;
  state_t state, state_nx;
  logic [15:0] wait_cnt;
  logic load_use, mem_stall, hold;
  assign load_use  = idex_mem_read && idex_rd != 5'd0 && (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
  assign mem_stall = !dmem_ready && ((state == RUN && exmem_mem_req) || state == MEM_WAIT);
  assign hold      = mem_stall || state == ERROR;
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      stall_count <= '0;
      mem_error   <= 1'b0;
    end else begin
      state       <= state_nx;
      wait_cnt    <= mem_stall ? (state == RUN ? 16'd1 : wait_cnt + 16'd1) : wait_cnt;
      mem_error   <= mem_error || state_nx == ERROR;
      stall_count <= (!pc_write && stall_count != '1) ? stall_count + STALL_CNT_W'(1) : stall_count;
    end
  end
  always_comb begin
    state_nx = state == ERROR ? ERROR : RUN;
    if (mem_stall) state_nx = (state == MEM_WAIT && wait_cnt == 16'(MEM_TIMEOUT)) ? ERROR : MEM_WAIT;
  end
  // a taken branch squashes the dependent instruction, so it overrides the load-use stall
  always_comb begin
    pc_write     = !reset && !hold && (ex_branch_taken || !load_use);
    ifid_write   = !reset && !hold && (ex_branch_taken || !load_use);
    ifid_flush   = !reset && !hold && ex_branch_taken;
    idex_write   = !reset && !hold;
    idex_flush   = !reset && !hold && (ex_branch_taken || load_use);
    exmem_write  = !reset && !hold;
    memwb_bubble = !reset && hold;
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench; main DUT uses MEM_TIMEOUT=4, second DUT uses a 4-bit stall counter
module tb_pipeline_hazard_ctrl;
  typedef struct packed {logic [6:0] c; logic e; logic [15:0] n;} exp_t;
  localparam logic [6:0] C_RUN = 7'b1101010, C_LU = 7'b0001110, C_BR = 7'b1111110, C_ST = 7'b0000001, C_RST = 7'b0000000;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] ifid_rs1 = '0, ifid_rs2 = '0, idex_rd = '0;
  logic idex_mem_read = 1'b0, ex_branch_taken = 1'b0, exmem_mem_req = 1'b0, dmem_ready = 1'b0;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_bubble, mem_error;
  logic [15:0] stall_count;
  logic s_pc, s_ifw, s_iff, s_idw, s_idf, s_exw, s_bub, s_err;
  logic [3:0] s_cnt;
  exp_t sb[$];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .STALL_CNT_W(16)) dut (
    .clk(clk), .reset(reset), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_rd(idex_rd),
    .idex_mem_read(idex_mem_read), .ex_branch_taken(ex_branch_taken), .exmem_mem_req(exmem_mem_req),
    .dmem_ready(dmem_ready), .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_write(idex_write), .idex_flush(idex_flush), .exmem_write(exmem_write),
    .memwb_bubble(memwb_bubble), .mem_error(mem_error), .stall_count(stall_count));
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(255), .STALL_CNT_W(4)) dut_sat (
    .clk(clk), .reset(reset), .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .idex_rd(idex_rd),
    .idex_mem_read(idex_mem_read), .ex_branch_taken(ex_branch_taken), .exmem_mem_req(exmem_mem_req),
    .dmem_ready(dmem_ready), .pc_write(s_pc), .ifid_write(s_ifw), .ifid_flush(s_iff),
    .idex_write(s_idw), .idex_flush(s_idf), .exmem_write(s_exw),
    .memwb_bubble(s_bub), .mem_error(s_err), .stall_count(s_cnt));
  function automatic exp_t obs();
    return {pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, memwb_bubble, mem_error, stall_count};
  endfunction
  function automatic exp_t obs_sat();
    return {s_pc, s_ifw, s_iff, s_idw, s_idf, s_exw, s_bub, s_err, 12'd0, s_cnt};
  endfunction
  function automatic logic [18:0] S(input logic [4:0] r1, r2, rd, input logic mr, br, rq, rdy);
    return {r1, r2, rd, mr, br, rq, rdy};
  endfunction
  function automatic exp_t E(input logic [6:0] c, input logic e, input int n);
    return {c, e, 16'(n)};
  endfunction
  task automatic apply(input logic [18:0] s);
    {ifid_rs1, ifid_rs2, idex_rd, idex_mem_read, ex_branch_taken, exmem_mem_req, dmem_ready} = s;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    apply('0);
    @(posedge clk); #1;
    reset = 1'b0;
  endtask
  task automatic test_reset();
    exp_t got, want;
    apply('0);
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      reset = (k == 0);
      sb.push_back(k == 0 ? E(C_RST, 0, 0) : E(C_RUN, 0, 0));
      @(negedge clk);
      got = obs(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL reset k=%0d got c=%b e=%b n=%0d want c=%b e=%b n=%0d", k, got.c, got.e, got.n, want.c, want.e, want.n); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_load_use();
    logic [18:0] st [6];
    exp_t ex [6];
    exp_t got, want;
    do_reset();
    st = '{S(0,0,0,0,0,0,0), S(1,5,5,1,0,0,0), S(1,5,5,0,0,0,0), S(0,0,0,0,0,0,0), S(7,0,7,1,0,0,0), S(0,0,0,0,0,0,0)};
    ex = '{E(C_RUN,0,0), E(C_LU,0,0), E(C_RUN,0,1), E(C_RUN,0,1), E(C_LU,0,1), E(C_RUN,0,2)};
    for (int k = 0; k < 6; k++) begin
      apply(st[k]); sb.push_back(ex[k]);
      @(negedge clk);
      got = obs(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL load_use k=%0d got c=%b e=%b n=%0d want c=%b e=%b n=%0d", k, got.c, got.e, got.n, want.c, want.e, want.n); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_x0_branch();
    logic [18:0] st [4];
    exp_t ex [4];
    exp_t got, want;
    do_reset();
    st = '{S(0,0,0,1,0,0,0), S(5,3,5,1,1,0,0), S(0,0,0,0,0,0,0), S(3,9,9,1,1,0,0)};
    ex = '{E(C_RUN,0,0), E(C_BR,0,0), E(C_RUN,0,0), E(C_BR,0,0)};
    for (int k = 0; k < 4; k++) begin
      apply(st[k]); sb.push_back(ex[k]);
      @(negedge clk);
      got = obs(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL x0_branch k=%0d got c=%b e=%b n=%0d want c=%b e=%b n=%0d", k, got.c, got.e, got.n, want.c, want.e, want.n); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_mem_wait();
    exp_t got, want;
    do_reset();
    for (int k = 0; k < 5; k++) begin
      apply(k < 3 ? S(0,0,0,0,0,1,0) : k == 3 ? S(0,0,0,0,0,1,1) : S(0,0,0,0,0,0,0));
      sb.push_back(k < 3 ? E(C_ST, 0, k) : E(C_RUN, 0, 3));
      @(negedge clk);
      got = obs(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL mem_wait k=%0d got c=%b e=%b n=%0d want c=%b e=%b n=%0d", k, got.c, got.e, got.n, want.c, want.e, want.n); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_zero_wait();
    logic [18:0] st [4];
    exp_t got, want;
    do_reset();
    st = '{S(0,0,0,0,0,1,1), S(0,0,0,0,0,1,1), S(0,0,0,0,0,0,0), S(0,0,0,0,0,0,1)};
    for (int k = 0; k < 4; k++) begin
      apply(st[k]); sb.push_back(E(C_RUN, 0, 0));
      @(negedge clk);
      got = obs(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL zero_wait k=%0d got c=%b e=%b n=%0d want c=%b e=%b n=%0d", k, got.c, got.e, got.n, want.c, want.e, want.n); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_back_to_back();
    logic [18:0] st [7];
    exp_t ex [7];
    exp_t got, want;
    do_reset();
    st = '{S(5,0,5,1,0,1,0), S(5,0,5,1,0,1,0), S(5,0,5,1,0,1,1), S(0,0,0,0,0,0,0),
           S(0,0,0,0,1,1,0), S(0,0,0,0,1,1,1), S(0,0,0,0,0,0,0)};
    ex = '{E(C_ST,0,0), E(C_ST,0,1), E(C_LU,0,2), E(C_RUN,0,3), E(C_ST,0,3), E(C_BR,0,4), E(C_RUN,0,4)};
    for (int k = 0; k < 7; k++) begin
      apply(st[k]); sb.push_back(ex[k]);
      @(negedge clk);
      got = obs(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL back_to_back k=%0d got c=%b e=%b n=%0d want c=%b e=%b n=%0d", k, got.c, got.e, got.n, want.c, want.e, want.n); end
      @(posedge clk); #1;
    end
  endtask
  task automatic test_timeout();
    exp_t got, want;
    do_reset();
    for (int k = 0; k < 14; k++) begin
      reset = (k == 12);
      apply(k < 10 ? S(0,0,0,0,0,1,0) : k < 12 ? S(0,0,0,0,0,1,1) : S(0,0,0,0,0,0,0));
      sb.push_back(k < 5 ? E(C_ST, 0, k) : k < 12 ? E(C_ST, 1, k) : k == 12 ? E(C_RST, 1, 12) : E(C_RUN, 0, 0));
      @(negedge clk);
      got = obs(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL timeout k=%0d got c=%b e=%b n=%0d want c=%b e=%b n=%0d", k, got.c, got.e, got.n, want.c, want.e, want.n); end
      @(posedge clk); #1;
    end
    reset = 1'b0;
  endtask
  task automatic test_saturation();
    exp_t got, want;
    do_reset();
    for (int k = 0; k < 22; k++) begin
      apply(k < 20 ? S(0,0,0,0,0,1,0) : S(0,0,0,0,0,0,1));
      sb.push_back(k < 20 ? E(C_ST, 0, k < 15 ? k : 15) : E(C_RUN, 0, 15));
      @(negedge clk);
      got = obs_sat(); want = sb.pop_front(); total++;
      if (got !== want) begin bad++; $display("FAIL saturation k=%0d got c=%b e=%b n=%0d want c=%b e=%b n=%0d", k, got.c, got.e, got.n, want.c, want.e, want.n); end
      @(posedge clk); #1;
    end
    do_reset();
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_x0_branch();
    test_mem_wait();
    test_zero_wait();
    test_back_to_back();
    test_timeout();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Drives the write-enable, flush and bubble controls of the IF/ID, ID/EX, EX/MEM and MEM/WB registers and the PC.
- Resolves load-use hazards, taken-branch redirects and multicycle data-memory accesses (req/ready handshake with timeout).
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MEM_TIMEOUT, 255, maximum consecutive wait cycles on a data-memory access before the error state is entered (1..65535).
- STALL_CNT_W, 16, width of the stall_count register.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ifid_rs1  in  5  rs1 of the instruction in ID.
- ifid_rs2  in  5  rs2 of the instruction in ID.
- idex_rd  in  5  rd of the instruction in EX.
- idex_mem_read  in  1  instruction in EX is a load.
- ex_branch_taken  in  1  branch/jump in EX resolved as taken.
- exmem_mem_req  in  1  instruction in MEM accesses data memory (load or store).
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC update enable.
- ifid_write  out  1  IF/ID load enable.
- ifid_flush  out  1  IF/ID clear to NOP.
- idex_write  out  1  ID/EX load enable.
- idex_flush  out  1  ID/EX clear (control fields to 0).
- exmem_write  out  1  EX/MEM load enable.
- memwb_bubble  out  1  MEM/WB captures RegWrite=0, MemToReg=0 this cycle.
- mem_error  out  1  sticky memory-timeout flag.
- stall_count  out  STALL_CNT_W  saturating count of cycles with pc_write=0.

Behaviour:
- FSM states: RUN, MEM_WAIT, ERROR. Reset enters RUN, clears wait_cnt, stall_count and mem_error.
- Control outputs are combinational from state and inputs, with one exception: while reset=1 they are forced to pc_write=ifid_write=idex_write=exmem_write=0, flushes=0, memwb_bubble=0.
- Default in RUN: all write enables 1, flushes 0, memwb_bubble 0.
- Priority 1 in RUN, memory stall: exmem_mem_req=1 and dmem_ready=0.
  - pc_write, ifid_write, idex_write and exmem_write are 0.
  - memwb_bubble=1; flushes=0.
  - Next state is MEM_WAIT; wait_cnt is loaded with 1.
- Priority 2 in RUN, taken branch: ex_branch_taken=1.
  - ifid_flush=1, idex_flush=1; pc_write=1 (redirect).
  - The load-use check is ignored.
- Priority 3 in RUN, load-use: idex_mem_read=1, idex_rd!=0, and idex_rd equals ifid_rs1 or ifid_rs2.
  - pc_write=0, ifid_write=0, idex_flush=1.
  - Exactly one bubble per hazard; the hazard clears on the next cycle because ID/EX then holds a NOP.
- MEM_WAIT with dmem_ready=0:
  - Outputs are identical to the memory-stall case; wait_cnt increments.
  - If wait_cnt==MEM_TIMEOUT, next state is ERROR.
- MEM_WAIT with dmem_ready=1:
  - All write enables 1, memwb_bubble 0; next state RUN.
  - Branch and load-use are evaluated this cycle with RUN priorities 2 and 3.
- A branch or load-use condition present during a memory stall is not lost: ID/EX and EX/MEM are frozen, so it re-presents on the release cycle.
- dmem_ready=1 in the same cycle as exmem_mem_req rises is a zero-wait access: no stall, state stays RUN.
- ERROR:
  - mem_error=1 (sticky); all write enables 0; memwb_bubble=1.
  - Left only via reset.
- stall_count increments on every non-reset cycle with pc_write=0 and saturates at all-ones.
- Reset mid-stall: the next cycle is RUN with counters cleared. No pending access is remembered.
- dmem_ready while exmem_mem_req=0 is ignored.

Test Plan:
1. Load-use: idex_mem_read=1, idex_rd=5, ifid_rs2=5 for one cycle, then idex_mem_read=0 -> exactly one cycle of pc_write=0, ifid_write=0, idex_flush=1; stall_count=1.
2. rd=x0 and branch priority:
   - idex_rd=0 matching rs1=0 -> no stall.
   - ex_branch_taken=1 together with a valid load-use -> ifid_flush=idex_flush=1, pc_write=1, stall_count unchanged.
3. Memory wait: exmem_mem_req=1, dmem_ready low for 3 cycles, then high.
   - 3 cycles of all writes 0 and memwb_bubble=1.
   - 4th cycle all writes 1, state RUN, stall_count=3.
4. Zero-wait access: exmem_mem_req=1 and dmem_ready=1 in the same cycle -> no stall, pc_write=1.
5. Timeout with MEM_TIMEOUT=4: exmem_mem_req=1, dmem_ready=0 held for 10 cycles.
   - ERROR entered after 5 stall cycles; mem_error=1 stays high and writes stay 0 after dmem_ready rises.
   - reset for 1 cycle -> mem_error=0, stall_count=0, pc_write=1.
6. Saturation with STALL_CNT_W=4: 20 consecutive load-use-free memory stalls (MEM_TIMEOUT=255) -> stall_count holds 15.
